// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the instruction prefetch queue.
//   fetch_state_e  : fetch FSM states (idle, request outstanding, discard stale response)
//   FETCH_PC_STEP  : byte increment between sequential instruction words
//   entry_width()  : packed width of one {instr, pc} queue entry
package fetch_queue_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StReq     = 2'd1,
        StDiscard = 2'd2
    } fetch_state_e;

    localparam int unsigned FETCH_PC_STEP = 4;

    // An entry carries two WIDTH-bit fields: instruction and its address.
    localparam int unsigned ENTRY_FIELDS = 2;

    function automatic int unsigned entry_width(input int unsigned width);
        return ENTRY_FIELDS * width;
    endfunction

endpackage

// File: rtl/fetch_queue_sync_fifo.sv
// Generic synchronous FIFO used as the prefetch buffer.
// Ports:
//   clk, rst        : rising-edge clock, synchronous active-low reset
//   push, push_data : write one entry (accepted when not full, or when popping in the same cycle)
//   pop             : remove the head entry (ignored when empty)
//   clear           : drop all entries; takes priority over push and pop
//   head_data       : current head entry
//   count           : number of occupied entries
//   full, empty     : occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_queue_sync_fifo #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    input  logic                     clear,
    output logic [DATA_W-1:0]        head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W:0]    count_q;
    logic              do_push;
    logic              do_pop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == FULL_COUNT);
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];

    assign do_pop  = pop && !empty;
    // A push into a full FIFO is fine when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            mem_q    <= '{default: '0};
        end else if (clear) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue in front of the IF/ID register. Fetches sequential words from a
// handshaked, variable-latency memory port into a small FIFO and presents {instr, pc} to the
// fetch stage. A redirect flushes the queue and restarts fetching at redirect_pc; a response
// already in flight when the redirect arrives is discarded.
// Ports:
//   clk, rst                 : rising-edge clock, synchronous active-low reset
//   redirect, redirect_pc    : flush and restart fetch at the given word-aligned address
//   mem_req, mem_addr        : memory request and its address (held until mem_ack)
//   mem_ack, mem_rdata       : request completion and read data
//   out_valid, out_ready     : head handshake towards the IF stage
//   out_instr, out_pc        : head instruction and its address
//   count                    : occupied queue entries
// Build option: define FETCH_QUEUE_BYPASS_EN to let a response landing in an empty queue
// appear on out_* in the same cycle (and be consumed without being stored if out_ready=1).
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned      WIDTH    = 32,
    parameter int unsigned      DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     redirect,
    input  logic [WIDTH-1:0]         redirect_pc,
    output logic                     mem_req,
    output logic [WIDTH-1:0]         mem_addr,
    input  logic                     mem_ack,
    input  logic [WIDTH-1:0]         mem_rdata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_instr,
    output logic [WIDTH-1:0]         out_pc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned      CNT_W   = $clog2(DEPTH) + 1;
    localparam int unsigned      ENTRY_W = entry_width(WIDTH);
    localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(FETCH_PC_STEP);
    localparam logic [CNT_W-1:0] CAP     = CNT_W'(DEPTH);

    typedef struct packed {
        logic [WIDTH-1:0] instr;
        logic [WIDTH-1:0] pc;
    } entry_t;

    fetch_state_e     state_q;
    logic [WIDTH-1:0] fetch_pc_q;
    logic [WIDTH-1:0] fetch_pc_pending_q;

    entry_t           push_entry;
    entry_t           head_entry;
    logic [ENTRY_W-1:0] head_bits;
    logic             ack_push;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] count_next;
    logic             room_next;

    assign mem_req  = (state_q != StIdle);
    assign mem_addr = fetch_pc_q;
    assign count    = fifo_count;

    // A response is only kept when no redirect arrives alongside it.
    assign ack_push   = (state_q == StReq) && mem_ack && !redirect;
    assign push_entry = '{instr: mem_rdata, pc: fetch_pc_q};
    assign head_entry = entry_t'(head_bits);

    // Redirect wins over a handshake on the head: the entry is flushed, not consumed.
    assign fifo_pop = out_ready && !fifo_empty && !redirect;

`ifdef FETCH_QUEUE_BYPASS_EN
    logic bypass;

    assign bypass    = ack_push && fifo_empty;
    assign fifo_push = ack_push && !(bypass && out_ready) && (!fifo_full || fifo_pop);
    assign out_valid = !fifo_empty || bypass;
    assign out_instr = bypass ? mem_rdata  : head_entry.instr;
    assign out_pc    = bypass ? fetch_pc_q : head_entry.pc;
`else
    assign fifo_push = ack_push && (!fifo_full || fifo_pop);
    assign out_valid = !fifo_empty;
    assign out_instr = head_entry.instr;
    assign out_pc    = head_entry.pc;
`endif

    assign count_next = fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
    assign room_next  = (count_next < CAP);

    fetch_queue_sync_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .clear     (redirect),
        .head_data (head_bits),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q            <= StIdle;
            fetch_pc_q         <= RESET_PC;
            fetch_pc_pending_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (redirect) begin
                        fetch_pc_q <= redirect_pc;
                        state_q    <= StReq;
                    end else if (room_next) begin
                        state_q <= StReq;
                    end
                end
                StReq: begin
                    if (redirect) begin
                        if (mem_ack) begin
                            fetch_pc_q <= redirect_pc;
                        end else begin
                            // mem_addr must stay put until the stale response returns.
                            fetch_pc_pending_q <= redirect_pc;
                            state_q            <= StDiscard;
                        end
                    end else if (mem_ack) begin
                        fetch_pc_q <= fetch_pc_q + PC_STEP;
                        if (!room_next) begin
                            state_q <= StIdle;
                        end
                    end
                end
                StDiscard: begin
                    if (mem_ack) begin
                        fetch_pc_q <= redirect ? redirect_pc : fetch_pc_pending_q;
                        state_q    <= StReq;
                    end else if (redirect) begin
                        fetch_pc_pending_q <= redirect_pc;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction prefetch queue sitting directly upstream of the IF/ID pipeline register. It replaces the zero-latency combinational instruction-memory read with a handshaked, variable-latency memory port. It fetches sequential words ahead of the pipeline into a small FIFO and hands {instr, pc} to the fetch stage with a valid/ready handshake. A redirect from the ID-stage branch/jump resolution flushes the queue and restarts fetch at the new address.

## Interface
- WIDTH, 32: instruction and address width.
- DEPTH, 4: queue entries; power of two, at least 2.
- RESET_PC, 32'h0: first fetch address after reset.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset; one clock; reset is synchronous and active-low.
- redirect  in  1  flush the queue and restart fetch at redirect_pc.
- redirect_pc  in  WIDTH  new fetch address; word-aligned.
- mem_req  out  1  memory request.
- mem_addr  out  WIDTH  request address.
- mem_ack  in  1  memory completes the current request this cycle.
- mem_rdata  in  WIDTH  read data, valid when mem_ack=1.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  IF stage accepts the head; low during MemStall.
- out_instr  out  WIDTH  head instruction.
- out_pc  out  WIDTH  head address.
- count  out  $clog2(DEPTH)+1  occupied entries.

## Operation
- States: IDLE, REQ, DISCARD. mem_req = (state != IDLE).
- fetch_pc register drives mem_addr. It stays stable while mem_req=1 and mem_ack=0.
- IDLE → REQ when count_next < DEPTH. Otherwise stay in IDLE; the queue is full.
- REQ with mem_ack and no redirect: push {mem_rdata, fetch_pc}, then fetch_pc += 4 (wraps modulo 2^WIDTH). Stay in REQ if count_next < DEPTH, else go to IDLE.
- REQ with redirect and no mem_ack: the in-flight response must be dropped. Latch redirect_pc into fetch_pc_pending and go to DISCARD. mem_addr holds the old address until the ack.
- REQ with redirect and mem_ack in the same cycle: drop mem_rdata, set fetch_pc = redirect_pc, stay in REQ.
- DISCARD with mem_ack: drop the data, set fetch_pc = fetch_pc_pending, go to REQ.
- DISCARD with a further redirect: overwrite fetch_pc_pending; the newest redirect wins.
- IDLE with redirect: set fetch_pc = redirect_pc and go to REQ.
- Pop: out_valid and out_ready both high. A pop and a push in the same cycle leaves count unchanged, and the push is legal even when full.
- Redirect has priority over push and pop. The queue empties (count=0, out_valid=0 next cycle) and a simultaneous pop is ignored.
- Entries are never reordered. out_pc of consecutive pops differs by 4 unless a redirect occurs between them.

## Timing
- Reset values: state=IDLE, mem_req=0, mem_addr=RESET_PC, out_valid=0, out_instr=0, out_pc=0, count=0, fetch_pc_pending=0.
- The first mem_req rises in the cycle after rst deasserts.
- mem_ack may be high in the same cycle mem_req first rises, so a zero-wait memory sustains 1 fetch/cycle.
- Push-to-out_valid latency is 1 cycle (registered FIFO).
- Redirect-to-first-new-request latency: 0 cycles in IDLE or REQ (the new address is on mem_addr next cycle). In DISCARD it is the remaining memory latency plus 1 cycle.
- Reset asserted mid-request drops mem_req the next cycle. The memory must tolerate an abandoned request.
- count, out_* and mem_addr are registered. mem_req is decoded from state only, with no combinational path from mem_ack.

## Configuration
- FETCH_QUEUE_BYPASS_EN defined: when the queue is empty and a push occurs, mem_rdata/fetch_pc drive out_instr/out_pc combinationally with out_valid=1 in the same cycle. If out_ready=1, the entry is consumed without being written.
- Not defined: the registered path only, with 1-cycle push-to-valid latency.

## Structure
- Shared package: fetch-state enum (IDLE, REQ, DISCARD), FETCH_PC_STEP = 4, and a {instr, pc} entry struct/width constant.
- Sub-module sync_fifo: generic DEPTH×(2·WIDTH) FIFO with push, pop, clear, count, full and empty. The FSM, pc tracking and bypass stay in fetch_queue.

## Test plan
- Zero-wait memory (ack=mem_req), out_ready=1 after reset: out_pc = 0, 4, 8, 12 on consecutive cycles, and count never exceeds 1.
- out_ready=0, zero-wait memory: count saturates at 4, mem_req=0 from then on, and mem_addr holds 16. Raising out_ready resumes requests the next cycle.
- 3-cycle memory, redirect to 0x100 one cycle after the request at 0x8: the 0x8 response is dropped, the next mem_addr is 0x100, and the first out_pc is 0x100.
- Redirect to 0x40 coinciding with mem_ack for 0x10: 0x10 is not queued, mem_addr becomes 0x40 next cycle, and the queue is empty.
- Two redirects (0x80, then 0xC0) during DISCARD: only 0xC0 is fetched afterwards.
- rst low mid-request with 2 entries queued: next cycle count=0, out_valid=0, mem_req=0, mem_addr=RESET_PC. With FETCH_QUEUE_BYPASS_EN, empty queue and ack with rdata=0x13: out_valid=1 in the same cycle.
